discharge_sequencer: RTL and testbench

DISCHARGE_SEQUENCER -- requirements
Module: discharge_sequencer

---
 rtl/discharge_sequencer.sv | 155 +++++++++++++++
 tb/tb_discharge_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/discharge_sequencer.sv
// Discharge pulse sequencer: WAIT for breakdown, drive BUCK/RES for on_time, then deionize.
// Optional compile macro WAIT_TIMEOUT_EN adds a latched wait timeout and a timeout_flag strobe.
module discharge_sequencer #(
    parameter logic [31:0] MIN_OFF_CYCLES       = 32'd100,
    parameter logic [31:0] DEFAULT_WAIT_TIMEOUT = 32'd400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] waveform,
    input  logic [31:0] on_time,
    input  logic [31:0] off_time,
    input  logic        is_breakdown,
`ifdef WAIT_TIMEOUT_EN
    input  logic [31:0] wait_timeout,
    output logic        timeout_flag,
`endif
    output logic [7:0]  current_state,
    output logic [31:0] timer_wait_breakdown,
    output logic        gate_main,
    output logic        gate_buck,
    output logic        gate_res,
    output logic        pulse_done,
    output logic [31:0] pulse_count
);
    localparam logic [7:0] S_IDLE  = 8'h00;
    localparam logic [7:0] S_WAIT  = 8'h01;
    localparam logic [7:0] S_BUCK  = 8'h02;
    localparam logic [7:0] S_RES   = 8'h04;
    localparam logic [7:0] S_DEION = 8'h80;

    logic [7:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  wf_q, wf_d;           // {buck, continuous}
    logic [31:0] on_q, on_d, off_q, off_d;
    logic        gate_main_q, gate_main_d, gate_buck_q, gate_buck_d, gate_res_q, gate_res_d;
    logic        pulse_done_q, pulse_done_d;
    logic [31:0] pulse_count_q, pulse_count_d;
    logic [31:0] on_len, off_len;
    logic        hit_on, hit_off, idle_done, timeout_hit, timeout_d, enter_wait;
    logic [7:0]  exit_state;
    logic        unused_bits;

    assign unused_bits = ^{waveform[13:0], DEFAULT_WAIT_TIMEOUT};

`ifdef WAIT_TIMEOUT_EN
    logic [31:0] limit_q, limit_d;
    logic        tflag_q;
    assign timeout_hit  = (limit_q != 32'd0) && (timer_q == limit_q);
    assign limit_d      = enter_wait ? wait_timeout : limit_q;
    assign timeout_flag = tflag_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q <= DEFAULT_WAIT_TIMEOUT;
            tflag_q <= 1'b0;
        end else begin
            limit_q <= limit_d;
            tflag_q <= timeout_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        on_len     = (on_q == 32'd0) ? 32'd1 : on_q;
        off_len    = (off_q < MIN_OFF_CYCLES) ? MIN_OFF_CYCLES : off_q;
        // compare in 33 bits so a full-scale length cannot wrap
        hit_on     = ({1'b0, cnt_q} + 33'd1) >= {1'b0, on_len};
        hit_off    = ({1'b0, cnt_q} + 33'd1) >= {1'b0, off_len};
        idle_done  = done_q || hit_off;
        exit_state = wf_q[0] ? S_DEION : S_IDLE;
        state_d    = state_q;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE:  if (idle_done && enable && (wf_q[0] || start)) state_d = S_WAIT;
            S_WAIT: begin
                if (!enable)           state_d = exit_state;
                else if (is_breakdown) state_d = wf_q[1] ? S_BUCK : S_RES;
                else if (timeout_hit) begin
                    state_d   = exit_state;
                    timeout_d = 1'b1;
                end
            end
            S_BUCK, S_RES: if (!enable || hit_on) state_d = exit_state;
            S_DEION: if (hit_off) state_d = enable ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        enter_wait = (state_d == S_WAIT) && (state_q != S_WAIT);
        wf_d  = enter_wait ? waveform[15:14] : wf_q;
        on_d  = enter_wait ? on_time : on_q;
        off_d = enter_wait ? off_time : off_q;

        if (state_d != state_q)        cnt_d = 32'd0;
        else if (cnt_q == 32'hFFFFFFFF) cnt_d = cnt_q;
        else                            cnt_d = cnt_q + 32'd1;
        done_d = (state_d == S_IDLE) &&
                 ((state_q == S_IDLE && idle_done) || state_q == S_DEION);

        if (state_d == S_WAIT && state_q == S_WAIT)
            timer_d = (timer_q == 32'hFFFFFFFF) ? timer_q : timer_q + 32'd1;
        else
            timer_d = 32'd0;

        pulse_done_d  = (state_q == S_BUCK || state_q == S_RES) &&
                        !(state_d == S_BUCK || state_d == S_RES);
        pulse_count_d = (state_q == S_WAIT && (state_d == S_BUCK || state_d == S_RES))
                        ? pulse_count_q + 32'd1 : pulse_count_q;
        gate_main_d   = (state_d == S_WAIT) || (state_d == S_BUCK) || (state_d == S_RES);
        gate_buck_d   = (state_d == S_BUCK);
        gate_res_d    = (state_d == S_RES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 32'd0;
            done_q        <= 1'b1;
            timer_q       <= 32'd0;
            wf_q          <= 2'b00;
            on_q          <= 32'd0;
            off_q         <= 32'd0;
            gate_main_q   <= 1'b0;
            gate_buck_q   <= 1'b0;
            gate_res_q    <= 1'b0;
            pulse_done_q  <= 1'b0;
            pulse_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            timer_q       <= timer_d;
            wf_q          <= wf_d;
            on_q          <= on_d;
            off_q         <= off_d;
            gate_main_q   <= gate_main_d;
            gate_buck_q   <= gate_buck_d;
            gate_res_q    <= gate_res_d;
            pulse_done_q  <= pulse_done_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    assign current_state        = state_q;
    assign timer_wait_breakdown = timer_q;
    assign gate_main            = gate_main_q;
    assign gate_buck            = gate_buck_q;
    assign gate_res             = gate_res_q;
    assign pulse_done           = pulse_done_q;
    assign pulse_count          = pulse_count_q;
endmodule

// File: tb/tb_discharge_sequencer.sv
// Directed bench for discharge_sequencer; expectations queued with stimulus, popped at sample points.
module tb_discharge_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, start = 1'b0, is_breakdown = 1'b0;
    logic [15:0] waveform = 16'h0;
    logic [31:0] on_time = 32'd0, off_time = 32'd0;
    logic [7:0]  current_state;
    logic [31:0] timer_wait_breakdown, pulse_count;
    logic        gate_main, gate_buck, gate_res, pulse_done;
`ifdef WAIT_TIMEOUT_EN
    logic [31:0] wait_timeout = 32'd0;
    logic        timeout_flag;
`endif

    discharge_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .waveform(waveform),
        .on_time(on_time), .off_time(off_time), .is_breakdown(is_breakdown),
`ifdef WAIT_TIMEOUT_EN
        .wait_timeout(wait_timeout), .timeout_flag(timeout_flag),
`endif
        .current_state(current_state), .timer_wait_breakdown(timer_wait_breakdown),
        .gate_main(gate_main), .gate_buck(gate_buck), .gate_res(gate_res),
        .pulse_done(pulse_done), .pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    typedef struct { string tag; logic [31:0] exp; } exp_t;
    exp_t sb[$];
    int n_tests = 0, n_fail = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: observed %0h with no expectation queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // counts samples spent in a state, bounded so a stuck DUT still terminates
    task automatic measure(input logic [7:0] code, output int n);
        n = 0;
        while (current_state === code && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        #2;
        expect_v("rst_state", 8'h00);  check(current_state);
        expect_v("rst_gmain", 0);      check(gate_main);
        expect_v("rst_pcount", 0);     check(pulse_count);
        expect_v("rst_timer", 0);      check(timer_wait_breakdown);
        expect_v("rst_pdone", 0);      check(pulse_done);
        step(); rst_n = 1'b1;

        // latched fields reset to single mode: no WAIT without a start
        enable = 1'b1; waveform = 16'hC000; on_time = 32'd50; off_time = 32'd200;
        expect_v("no_start_idle", 8'h00); step(3); check(current_state);
        start = 1'b1;
        expect_v("start_wait", 8'h01); step(); check(current_state);
        start = 1'b0;
        expect_v("wait_gmain", 1); check(gate_main);
        expect_v("wait_timer30", 30); step(30); check(timer_wait_breakdown);

        // continuous buck pulse
        is_breakdown = 1'b1;
        expect_v("buck_state", 8'h02); step(); check(current_state);
        is_breakdown = 1'b0;
        expect_v("buck_gate", 1);   check(gate_buck);
        expect_v("buck_pcount", 1); check(pulse_count);
        expect_v("buck_timer0", 0); check(timer_wait_breakdown);
        expect_v("buck_len", 50); measure(8'h02, n); check(n);
        expect_v("buck_exit_deion", 8'h80); check(current_state);
        expect_v("buck_exit_pdone", 1);     check(pulse_done);
        expect_v("deion_gmain", 0);         check(gate_main);
        waveform = 16'h4000; off_time = 32'd10;
        expect_v("deion_len200", 200); measure(8'h80, n); check(n);
        expect_v("deion_to_wait", 8'h01); check(current_state);

        // resistor pulse with deion floored at MIN_OFF_CYCLES
        step(3); is_breakdown = 1'b1;
        expect_v("res_state", 8'h04); step(); check(current_state);
        is_breakdown = 1'b0;
        expect_v("res_gate", 1);     check(gate_res);
        expect_v("res_nobuck", 0);   check(gate_buck);
        expect_v("res_pcount", 2);   check(pulse_count);
        expect_v("res_len", 50); measure(8'h04, n); check(n);
        expect_v("res_exit_pdone", 1); check(pulse_done);
        waveform = 16'hC000;
        expect_v("deion_min100", 100); measure(8'h80, n); check(n);
        expect_v("deion_wait2", 8'h01); check(current_state);

        // enable drop in BUCK while breakdown still asserted
        step(2); is_breakdown = 1'b1;
        expect_v("buck2_state", 8'h02); step(); check(current_state);
        expect_v("buck2_pcount", 3); check(pulse_count);
        step(4); enable = 1'b0;
        expect_v("abort_deion", 8'h80); step(); check(current_state);
        expect_v("abort_gmain", 0);  check(gate_main);
        expect_v("abort_gbuck", 0);  check(gate_buck);
        expect_v("abort_pdone", 1);  check(pulse_done);
        expect_v("abort_pcount", 3); check(pulse_count);
        is_breakdown = 1'b0;
        expect_v("abort_pdone_1cyc", 0); step(); check(pulse_done);
        expect_v("abort_deion_rest", 99); measure(8'h80, n); check(n);
        expect_v("deion_to_idle", 8'h00); check(current_state);
        expect_v("idle_hold_dis", 8'h00); step(3); check(current_state);

        // idle-done with latched continuous goes to WAIT on enable alone
        waveform = 16'h8000; on_time = 32'd20; enable = 1'b1;
        expect_v("idle_cont_wait", 8'h01); step(); check(current_state);
        step(2); is_breakdown = 1'b1;
        expect_v("single_buck", 8'h02); step(); check(current_state);
        is_breakdown = 1'b0;
        expect_v("single_len", 20); measure(8'h02, n); check(n);
        expect_v("single_idle", 8'h00); check(current_state);
        expect_v("single_pdone", 1);    check(pulse_done);
        expect_v("single_pcount", 4);   check(pulse_count);
        step(49); start = 1'b1;
        expect_v("early_start_ign", 8'h00); step(); check(current_state);
        start = 1'b0;
        expect_v("idle_no_start", 8'h00); step(100); check(current_state);
        start = 1'b1;
        expect_v("second_start", 8'h01); step(); check(current_state);
        start = 1'b0;

        // enable drop in WAIT, single mode -> IDLE_DEION
        enable = 1'b0;
        expect_v("wait_abort_idle", 8'h00); step(); check(current_state);
        expect_v("wait_abort_gm", 0); check(gate_main);
        waveform = 16'h0000; step(101); enable = 1'b1; start = 1'b1;
        expect_v("res_wait", 8'h01); step(); check(current_state);
        start = 1'b0;
        step(2); is_breakdown = 1'b1;
        expect_v("res2_state", 8'h04); step(); check(current_state);
        is_breakdown = 1'b0;
        expect_v("res2_gate", 1); check(gate_res);

        // async reset mid-RES, observed before the next rising edge
        step(3); #2 rst_n = 1'b0; #1;
        expect_v("arst_gres", 0);     check(gate_res);
        expect_v("arst_gmain", 0);    check(gate_main);
        expect_v("arst_state", 8'h00); check(current_state);
        expect_v("arst_pcount", 0);   check(pulse_count);
        step(); rst_n = 1'b1;

`ifdef WAIT_TIMEOUT_EN
        wait_timeout = 32'd1000; waveform = 16'h4000; enable = 1'b1; start = 1'b1;
        expect_v("to_wait", 8'h01); step(); check(current_state);
        start = 1'b0;
        expect_v("to_timer", 1000); step(1000); check(timer_wait_breakdown);
        expect_v("to_flag0", 0); check(timeout_flag);
        expect_v("to_deion", 8'h80); step(); check(current_state);
        expect_v("to_flag", 1);   check(timeout_flag);
        expect_v("to_pcount", 0); check(pulse_count);
        expect_v("to_flag_1cyc", 0); step(); check(timeout_flag);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
